// File: rtl/t03_load_store_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// t03_load_store_unit_if : req/ack word bus between the LSU and memory.
// Rev 1.0
// ---------------------------------------------------------------------------
interface t03_load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, sel, input ack, rdata);
  modport slave  (input req, we, addr, wdata, sel, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/t03_load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// t03_load_store_unit : memory stage, one bus transaction per request, then
// an aligned/extended register write or a store-done pulse.  Rev 1.0
// ---------------------------------------------------------------------------
module t03_load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   en,
  input  wire logic                   mem_op_valid,
  input  wire logic                   is_load,
  input  wire logic [2:0]             funct3,
  input  wire logic [31:0]            addr,
  input  wire logic [31:0]            store_data,
  input  wire logic [4:0]             rd_in,
  output logic                        busy,
  t03_load_store_unit_if.master       bus,
  output logic [4:0]                  rd_address,
  output logic                        register_write_en,
  output logic [31:0]                 register_write_data,
  output logic                        store_done,
  output logic                        misalign_err,
  output logic                        bus_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lo_q, lo_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             is_load_q, is_load_d;
  logic [4:0]       rd_q, rd_d;

  logic             busy_q, busy_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [3:0]       bus_sel_q, bus_sel_d;
  logic [4:0]       rd_address_q, rd_address_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             store_done_q, store_done_d;
  logic             misalign_q, misalign_d;
  logic             bus_err_q, bus_err_d;

  logic             req_illegal;
  logic             req_misaligned;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_ext;

  always_comb begin
    req_illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    req_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  // Load extraction works from the latched low address bits and width.
  always_comb begin
    rd_byte = bus.rdata[{lo_q, 3'b000} +: 8];
    rd_half = lo_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{rd_byte[7] & ~funct3_q[2]}}, rd_byte};
      2'b01:   load_ext = {{16{rd_half[15] & ~funct3_q[2]}}, rd_half};
      default: load_ext = bus.rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lo_d         = lo_q;
    funct3_d     = funct3_q;
    is_load_d    = is_load_q;
    rd_d         = rd_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_sel_d    = bus_sel_q;
    rd_address_d = rd_address_q;
    wr_en_d      = wr_en_q;
    wr_data_d    = wr_data_q;
    store_done_d = store_done_q;
    misalign_d   = misalign_q;
    bus_err_d    = bus_err_q;
    busy_d       = busy_q;

    // With en low every register, strobes included, simply holds.
    if (en) begin
      wr_en_d      = 1'b0;
      store_done_d = 1'b0;
      misalign_d   = 1'b0;
      bus_err_d    = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_op_valid) begin
            lo_d      = addr[1:0];
            funct3_d  = funct3;
            is_load_d = is_load;
            rd_d      = rd_in;
            if (req_illegal || req_misaligned) begin
              state_d    = S_ERR;
              misalign_d = 1'b1;
            end else begin
              state_d    = S_REQ;
              cnt_d      = '0;
              bus_req_d  = 1'b1;
              bus_we_d   = ~is_load;
              bus_addr_d = {addr[31:2], 2'b00};
              case (funct3[1:0])
                2'b00: begin
                  bus_sel_d   = 4'b0001 << addr[1:0];
                  bus_wdata_d = {4{store_data[7:0]}};
                end
                2'b01: begin
                  bus_sel_d   = addr[1] ? 4'b1100 : 4'b0011;
                  bus_wdata_d = {2{store_data[15:0]}};
                end
                default: begin
                  bus_sel_d   = 4'b1111;
                  bus_wdata_d = store_data;
                end
              endcase
            end
          end
        end
        S_REQ: begin
          if (bus.ack) begin
            bus_req_d = 1'b0;
            state_d   = S_WB;
            if (is_load_q) begin
              wr_data_d    = load_ext;
              rd_address_d = rd_q;
              wr_en_d      = (rd_q != 5'd0);
            end else begin
              store_done_d = 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            bus_req_d = 1'b0;
            bus_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WB:    state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lo_q         <= '0;
      funct3_q     <= '0;
      is_load_q    <= 1'b0;
      rd_q         <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_sel_q    <= '0;
      rd_address_q <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      store_done_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lo_q         <= lo_d;
      funct3_q     <= funct3_d;
      is_load_q    <= is_load_d;
      rd_q         <= rd_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_sel_q    <= bus_sel_d;
      rd_address_q <= rd_address_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      store_done_q <= store_done_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
      busy_q       <= busy_d;
    end
  end

  assign busy                = busy_q;
  assign bus.req             = bus_req_q;
  assign bus.we              = bus_we_q;
  assign bus.addr            = bus_addr_q;
  assign bus.wdata           = bus_wdata_q;
  assign bus.sel             = bus_sel_q;
  assign rd_address          = rd_address_q;
  assign register_write_en   = wr_en_q;
  assign register_write_data = wr_data_q;
  assign store_done          = store_done_q;
  assign misalign_err        = misalign_q;
  assign bus_err             = bus_err_q;

endmodule
`default_nettype wire
